// File: rtl/keypad_time_entry_pkg.sv
// rtl/keypad_time_entry_pkg.sv - shared types and constants for keypad time entry
// Contents: FSM state enum, BCD digit type, entry width and BCD limit.
package keypad_time_entry_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_QUAL,
    ST_HELD,
    ST_RELEASE_QUAL
  } key_state_t;

  localparam int unsigned MAX_DIGITS = 4;
  localparam bcd_digit_t  BCD_MAX    = 4'd9;

endpackage

// File: rtl/keypad_time_entry_qualifier.sv
// rtl/keypad_time_entry_qualifier.sv - consecutive-cycle qualifier shared by press and release
// Ports:
//   clock     : rising-edge clock
//   resetn    : synchronous active-low reset
//   restart   : first qualifying cycle, count loads 1
//   level_ok  : another consecutive qualifying cycle, count increments
//   qualified : the count reaches the threshold on this edge
// Build option KEYPAD_TIME_ENTRY_DEBOUNCE_EN: when undefined the counter is
// removed and the threshold is fixed at 1.
module key_qualifier #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic restart,
  input  logic level_ok,
  output logic qualified
);

`ifdef KEYPAD_TIME_ENTRY_DEBOUNCE_EN
  localparam logic [7:0] THRESH = 8'(DEBOUNCE_CYCLES);

  logic [7:0] count;
  logic [7:0] count_next;

  always_comb begin
    count_next = count;
    if (restart) begin
      count_next = 8'd1;
    end else if (level_ok && (count != 8'hFF)) begin
      count_next = count + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count <= 8'd0;
    end else begin
      count <= count_next;
    end
  end

  // Compare against the value the count takes at this edge, so the caller
  // acts on the same edge the threshold is reached.
  assign qualified = (restart || level_ok) && (count_next >= THRESH);
`else
  logic unused_qual;
  assign unused_qual = ^{clock, resetn, 8'(DEBOUNCE_CYCLES)};
  assign qualified   = restart | level_ok;
`endif

endmodule

// File: rtl/keypad_time_entry.sv
// rtl/keypad_time_entry.sv - debounced keypad digit entry into an MM:SS BCD register
// Ports:
//   clock, resetn           : clock and synchronous active-low reset
//   D, validn               : encoder digit and active-low valid
//   enablen                 : 1 allows entry, 0 freezes it
//   clearn                  : synchronous active-low cancel of the entry
//   min_tens..sec_ones      : BCD entry digits
//   digit_count             : accepted digits, saturating at 4
//   key_strobe              : one-cycle pulse per accepted digit
//   entry_nonzero           : any entry digit non-zero
// Build option KEYPAD_TIME_ENTRY_DEBOUNCE_EN selects DEBOUNCE_CYCLES qualification.
module keypad_time_entry
  import keypad_time_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] D,
  input  logic       validn,
  input  logic       enablen,
  input  logic       clearn,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] digit_count,
  output logic       key_strobe,
  output logic       entry_nonzero
);

  key_state_t state;
  bcd_digit_t d_q;
  bcd_digit_t cand;
  logic       validn_q;
  logic       restart;
  logic       level_ok;
  logic       qualified;
  logic       accept;

  key_qualifier #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_qual (
    .clock    (clock),
    .resetn   (resetn),
    .restart  (restart),
    .level_ok (level_ok),
    .qualified(qualified)
  );

  always_comb begin
    restart  = 1'b0;
    level_ok = 1'b0;
    case (state)
      ST_IDLE:         restart = !validn_q;
      ST_PRESS_QUAL: begin
        if (!validn_q) begin
          if (d_q != cand) restart  = 1'b1;
          else             level_ok = 1'b1;
        end
      end
      ST_HELD:         restart  = validn_q;
      ST_RELEASE_QUAL: level_ok = validn_q;
      default:         restart  = 1'b0;
    endcase
  end

  // Whenever a press qualifies, d_q equals the candidate, so d_q is the digit.
  assign accept = qualified && !validn_q &&
                  ((state == ST_IDLE) || (state == ST_PRESS_QUAL));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      d_q         <= '0;
      validn_q    <= 1'b1;
      cand        <= '0;
      state       <= ST_IDLE;
      min_tens    <= '0;
      min_ones    <= '0;
      sec_tens    <= '0;
      sec_ones    <= '0;
      digit_count <= '0;
      key_strobe  <= 1'b0;
    end else begin
      d_q        <= D;
      validn_q   <= validn;
      key_strobe <= 1'b0;
      if (!clearn) begin
        // A key still held re-qualifies from IDLE and is accepted again.
        state       <= ST_IDLE;
        min_tens    <= '0;
        min_ones    <= '0;
        sec_tens    <= '0;
        sec_ones    <= '0;
        digit_count <= '0;
      end else if (!enablen) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!validn_q) begin
              cand  <= d_q;
              state <= qualified ? ST_HELD : ST_PRESS_QUAL;
            end
          end
          ST_PRESS_QUAL: begin
            if (validn_q) begin
              state <= ST_IDLE;
            end else begin
              if (d_q != cand) cand <= d_q;
              if (qualified)   state <= ST_HELD;
            end
          end
          ST_HELD: begin
            if (validn_q) state <= qualified ? ST_IDLE : ST_RELEASE_QUAL;
          end
          ST_RELEASE_QUAL: begin
            if (!validn_q)     state <= ST_HELD;
            else if (qualified) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
        // Non-BCD codes still complete the press but leave the entry alone.
        if (accept && (d_q <= BCD_MAX)) begin
          min_tens   <= min_ones;
          min_ones   <= sec_tens;
          sec_tens   <= sec_ones;
          sec_ones   <= d_q;
          key_strobe <= 1'b1;
          if (digit_count < 3'(MAX_DIGITS)) digit_count <= digit_count + 3'd1;
        end
      end
    end
  end

  assign entry_nonzero = |{min_tens, min_ones, sec_tens, sec_ones};

endmodule

// File: tb/tb_keypad_time_entry.sv
// tb/tb_keypad_time_entry.sv - scoreboard bench for keypad_time_entry
module tb_keypad_time_entry;

`ifdef KEYPAD_TIME_ENTRY_DEBOUNCE_EN
  localparam int TH = 4;
`else
  localparam int TH = 1;
`endif

  logic       clock = 1'b0;
  logic       resetn, validn, enablen, clearn;
  logic [3:0] D;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [2:0] digit_count;
  logic       key_strobe, entry_nonzero;

  keypad_time_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .D            (D),
    .validn       (validn),
    .enablen      (enablen),
    .clearn       (clearn),
    .min_tens     (min_tens),
    .min_ones     (min_ones),
    .sec_tens     (sec_tens),
    .sec_ones     (sec_ones),
    .digit_count  (digit_count),
    .key_strobe   (key_strobe),
    .entry_nonzero(entry_nonzero)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    int         at;
    logic [3:0] mt, mo, st, so;
    logic [2:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  logic [3:0] m_mt = 0, m_mo = 0, m_st = 0, m_so = 0;
  logic [2:0] m_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic push_accept(input logic [3:0] d, input int at);
    exp_t e;
    m_mt = m_mo; m_mo = m_st; m_st = m_so; m_so = d;
    if (m_cnt < 3'd4) m_cnt = m_cnt + 3'd1;
    e.at = at; e.mt = m_mt; e.mo = m_mo; e.st = m_st; e.so = m_so; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe must match the oldest pending expected accept.
  always @(negedge clock) begin
    if (resetn && key_strobe) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe: unexpected strobe at cycle %0d digits %h%h:%h%h", cyc,
                 min_tens, min_ones, sec_tens, sec_ones);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.at != cyc || e.mt !== min_tens || e.mo !== min_ones || e.st !== sec_tens ||
            e.so !== sec_ones || e.cnt !== digit_count) begin
          errors++;
          $display("FAIL strobe: got cyc=%0d %h%h:%h%h cnt=%0d expected cyc=%0d %h%h:%h%h cnt=%0d",
                   cyc, min_tens, min_ones, sec_tens, sec_ones, digit_count,
                   e.at, e.mt, e.mo, e.st, e.so, e.cnt);
        end
      end
    end
  end

  task automatic press(input logic [3:0] d, input int hold, input int rel, input bit expect_acc);
    @(negedge clock);
    D = d; validn = 1'b0;
    if (expect_acc) push_accept(d, cyc + 1 + TH);
    repeat (hold) @(negedge clock);
    validn = 1'b1;
    repeat (rel) @(negedge clock);
  endtask

  task automatic check_digits(input string name);
    check({name, "_digits"}, {min_tens, min_ones, sec_tens, sec_ones}, {m_mt, m_mo, m_st, m_so});
    check({name, "_count"}, digit_count, m_cnt);
  endtask

  task automatic clear_pulse();
    @(negedge clock);
    clearn = 1'b0;
    @(negedge clock);
    clearn = 1'b1;
    m_mt = 0; m_mo = 0; m_st = 0; m_so = 0; m_cnt = 0;
  endtask

  initial begin
    resetn = 1'b0; validn = 1'b0; D = 4'd5; enablen = 1'b1; clearn = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    check("reset_count", digit_count, 3'd0);
    check("reset_strobe", key_strobe, 1'b0);
    check("reset_nonzero", entry_nonzero, 1'b0);
    validn = 1'b1;
    @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(negedge clock);

    press(4'd1, 10, 10, 1'b1);
    press(4'd2, 10, 10, 1'b1);
    press(4'd3, 10, 10, 1'b1);
    press(4'd4, 10, 10, 1'b1);
    check("entry_1234", {min_tens, min_ones, sec_tens, sec_ones}, 16'h1234);
    check("entry_count4", digit_count, 3'd4);
    press(4'd5, 10, 10, 1'b1);
    check("entry_2345", {min_tens, min_ones, sec_tens, sec_ones}, 16'h2345);
    check("entry_count_sat", digit_count, 3'd4);

`ifdef KEYPAD_TIME_ENTRY_DEBOUNCE_EN
    // Short glitch: 3 low cycles never qualifies.
    press(4'd7, 3, 10, 1'b0);
    // Digit changes 7 -> 8 after two cycles; only 8 is accepted.
    @(negedge clock);
    D = 4'd7; validn = 1'b0;
    repeat (2) @(negedge clock);
    D = 4'd8;
    push_accept(4'd8, cyc + 1 + TH);
    repeat (10) @(negedge clock);
    validn = 1'b1;
    repeat (10) @(negedge clock);
    check("entry_3458", {min_tens, min_ones, sec_tens, sec_ones}, 16'h3458);
`else
    // Long hold produces a single accept one edge after validn_q falls.
    press(4'd6, 30, 10, 1'b1);
    check("entry_3456", {min_tens, min_ones, sec_tens, sec_ones}, 16'h3456);
`endif

    // Frozen entry ignores a long press.
    @(negedge clock);
    enablen = 1'b0;
    press(4'd9, 20, 10, 1'b0);
    check_digits("freeze");
    enablen = 1'b1;

    clear_pulse();
    check_digits("clear1");
    press(4'd4, 10, 10, 1'b1);
    press(4'd5, 10, 10, 1'b1);
    check("entry_0045", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0045);
    check("nonzero_0045", entry_nonzero, 1'b1);

    // Non-BCD code: FSM completes the press but no shift and no strobe.
    press(4'hA, 10, 10, 1'b0);
    check("invalid_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0045);
    check("invalid_count", digit_count, 3'd2);

    clear_pulse();
    check("clear_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    check("clear_nonzero", entry_nonzero, 1'b0);
    check("clear_count", digit_count, 3'd0);

`ifdef KEYPAD_TIME_ENTRY_DEBOUNCE_EN
    // Two-cycle release bounce inside one hold still gives one accept.
    @(negedge clock);
    D = 4'd3; validn = 1'b0;
    push_accept(4'd3, cyc + 1 + TH);
    repeat (10) @(negedge clock);
    validn = 1'b1;
    repeat (2) @(negedge clock);
    validn = 1'b0;
    repeat (5) @(negedge clock);
    validn = 1'b1;
    repeat (10) @(negedge clock);
    check("bounce_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0003);
    check("bounce_count", digit_count, 3'd1);
`else
    press(4'd7, 10, 10, 1'b1);
    check("single_7", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0007);
`endif

    repeat (20) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected strobes never seen, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
